// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder cell plus a registered carry, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for op_a - op_b.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1; carry_out then reads as "no borrow".
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1  : carry_in;
`else
  assign b_load = op_b;
  assign c_load = carry_in;
`endif

  fulladder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum_sh[0].
  assign sum_nxt = WIDTH'({fa_s, sum_sh} >> 1);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh      <= op_a;
          b_sh      <= b_load;
          carry_reg <= c_load;
          cnt       <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          sum_sh    <= sum_nxt;
          carry_reg <= fa_co;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum       <= sum_nxt;
            carry_out <= fa_co;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with a result scoreboard queue.
// Define SERIAL_ADDER_SUB_EN to also exercise subtraction.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif

  int n_checks = 0;
  int n_err = 0;
  logic [W:0] sb_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    logic [W-1:0] be;
    logic         ce;
    be = b;
    ce = c;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      be = ~b;
      ce = 1'b1;
    end
`endif
    return {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
  endfunction

  // Waits (bounded) for out_valid; returns cycles elapsed since the caller's reference edge.
  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [W:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_sum"}, sum, e[W-1:0]);
      chk({tag, "_cout"}, carry_out, e[W]);
    end
  endtask

  // One full transaction; 'stall' cycles of backpressure with junk in_valid attempts.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input int stall);
    int lat;
    logic [W-1:0] held;
    chk({tag, "_in_ready_pre"}, in_ready, 1);
    op_a = a; op_b = b; carry_in = c; in_valid = 1'b1; out_ready = 1'b0;
    sb_q.push_back(model(a, b, c));
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, in_ready, 0);
    wait_out(0, lat);
    chk({tag, "_latency"}, lat, W);
    check_result(tag);
    held = sum;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; op_a = 8'hAA; op_b = 8'h55; carry_in = 1'b1;
      tick();
      chk({tag, "_bp_valid"}, out_valid, 1);
      chk({tag, "_bp_sum"}, sum, held);
      chk({tag, "_bp_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_sum", sum, 0);
      chk("idle_cout", carry_out, 0);
    end

    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 0);

    // Back-to-back with in_valid/out_ready held high.
    op_a = 8'hA5; op_b = 8'h5A; carry_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    sb_q.push_back(model(8'hA5, 8'h5A, 1'b1));
    tick();
    op_a = 8'h12; op_b = 8'h34; carry_in = 1'b0;
    sb_q.push_back(model(8'h12, 8'h34, 1'b0));
    wait_out(0, lat);
    chk("b2b_lat1", lat, W);
    check_result("b2b1");
    tick();
    wait_out(lat + 1, lat);
    chk("b2b_lat2", lat, 2 * W + 2);
    check_result("b2b2");
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle", in_ready, 1);
    tick();
    chk("b2b_no_accept", in_ready, 1);

    do_op("bp", 8'h0F, 8'h01, 1'b0, 5);

    // Reset in the middle of SHIFT: no output, outputs clear at once.
    op_a = 8'h77; op_b = 8'h11; carry_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", carry_out, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("after_rst", 8'h01, 8'h02, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op("sub_5_7", 8'h05, 8'h07, 1'b0, 0);
    do_op("sub_7_5", 8'h07, 8'h05, 1'b0, 0);
    sub = 1'b0;
    do_op("sub0_add", 8'h20, 8'h03, 1'b1, 0);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
